sound_cmd_port: RTL and testbench
=================================

# sound_cmd_port

Parametrised command interface in front of the sound board. It accepts sound commands from NCH independent game-side sources through valid/ready handshakes, arbitrates round-robin, and buffers them in a DEPTH-entry FIFO. It then replays each command onto the board's active-low `pb`/`hand` lines with a fixed assert time and a recovery gap, so every command produces exactly one clean CB1 interrupt edge on the sound CPU's PIA. It replaces direct wiring of `pb`/`hand` from a single latch.

## Interface
- NCH, 2: number of requesting sources, ≥1
- CMD_W, 6: command width, equals the width of `pb`
- DEPTH, 4: FIFO entries; power of two, ≥2
- HOLD_CYC, 16: cycles a command is driven on `pb`/`hand`; ≥1
- GAP_CYC, 8: idle cycles after each command; ≥0
- clk_cpu  in  1  sole clock, sound CPU clock domain
- reset  in  1  synchronous, active-high
- req_valid  in  NCH  per-source command valid
- req_cmd  in  NCH*CMD_W  source i at [i*CMD_W +: CMD_W]
- req_ready  out  NCH  one-hot or zero grant; accept = valid & ready at rising edge
- pb  out  CMD_W  active-low command bits to sound board; idle all ones
- hand  out  1  active-low strobe to sound board; idle 1
- busy  out  1  FIFO non-empty or FSM not IDLE
- level  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Arbitration:
  - Round-robin pointer `rr` (reset 0).
  - The grant goes to the first valid source at or after `rr` (modulo NCH), only when level < DEPTH and reset is low.
  - `req_ready` is combinational from `req_valid`, `rr` and the registered `level`.
  - On an accept, `rr` moves to granted+1 mod NCH. Without an accept, `rr` holds.
- Command 0 is a no-op: it is accepted (handshake completes, `rr` advances) but not enqueued, since `pb` = ~0 is the idle level and cannot raise CB1.
- Each non-zero command is written into the FIFO. The encoding is `pb` = ~cmd.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: `pb` all ones, `hand`=1. If level>0, pop the head, load `pb`<=~cmd and `hand`<=0, and go to DRIVE with the counter set to HOLD_CYC-1.
  - DRIVE: hold the outputs. At counter 0, restore `pb` to all ones and `hand` to 1. Go to GAP with the counter set to GAP_CYC-1, or go straight to IDLE if GAP_CYC=0.
  - GAP: outputs idle. At counter 0, go to IDLE.
- Outputs are registered directly from the FSM datapath, with no combinational path from `req_*`.
- Full FIFO: the not-full check uses registered `level`, so a pop and a push never both happen against a full FIFO in the same cycle. `level` never exceeds DEPTH.
- Empty FIFO: IDLE holds with idle outputs. There is no underflow path.
- Reset values: `pb`=all ones, `hand`=1, `busy`=0, `level`=0, `req_ready`=0, state IDLE, `rr`=0, FIFO pointers 0.
- Reset mid-operation: a command being driven is aborted and the outputs return to idle on the reset edge. Queued commands are discarded.

## Timing
- Accept at edge k into an empty FIFO with the FSM in IDLE:
  - `level`=1 after edge k.
  - Pop at edge k+1, so `pb`/`hand` assert after edge k+1.
  - Held for exactly HOLD_CYC cycles, then idle for GAP_CYC cycles.
- Back-to-back queued commands start every 1+HOLD_CYC+GAP_CYC cycles. The extra cycle is the IDLE pop.
- At most one accept per cycle across all sources.
- A push and a pop in the same cycle leave `level` unchanged.
- Counter width is $clog2(max(HOLD_CYC,GAP_CYC,2)).

## Structure
- Shared package `snd_pkg`:
  - state enum (IDLE, DRIVE, GAP)
  - `PB_IDLE` constant generator (all ones of CMD_W)
- Sub-module `snd_cmd_fifo`: synchronous DEPTH×CMD_W FIFO with push/pop/level and wrap-around pointers of width $clog2(DEPTH).
- Arbiter and FSM live in the top module.

## Test plan
- Reset then idle 20 cycles -> `pb`=6'h3F, `hand`=1, `busy`=0, `level`=0, `req_ready`=0 while reset high.
- Source 0 sends 6'h0A at edge k -> `pb`=6'h35, `hand`=0 from edge k+1 for 16 cycles, then idle 8 cycles. `busy` drops at edge k+25.
- Both sources valid continuously with 6'h01/6'h02 -> accepts alternate 0,1,0,1. The `pb` sequence is 3E,3D,3E,3D… with a 25-cycle period.
- Fill to DEPTH=4 while the FSM is in DRIVE -> `req_ready`=0 with `level`=4. The next accept happens only after the next IDLE pop. Queue order is preserved.
- Source 1 sends 6'h00 -> handshake completes, `level` stays 0, `pb` stays 3F, `rr` advances to 0.
- Assert reset for 1 cycle during DRIVE with 3 queued commands -> outputs return to idle on that edge and `level`=0. No further `pb` activity follows.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared types and constant helpers for the sound-board command port.
package snd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } snd_state_e;

    localparam int unsigned SND_MAX_W = 64;

    // Idle level of the active-low command bus: the low w bits set.
    function automatic logic [SND_MAX_W-1:0] pb_idle(input int unsigned w);
        logic [SND_MAX_W-1:0] r;
        for (int unsigned i = 0; i < SND_MAX_W; i++) begin
            r[i] = (i < w) ? 1'b1 : 1'b0;
        end
        return r;
    endfunction

    // Width of the shared hold/gap down-counter.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
        int unsigned m;
        m = 2;
        m = (hold > m) ? hold : m;
        m = (gap > m) ? gap : m;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/snd_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers and an occupancy count.
module snd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Guard against overflow/underflow even if the caller misbehaves.
    always_comb begin
        push_ok_s = push_i && (level_q != LVL_W'(DEPTH));
        pop_ok_s  = pop_i && (level_q != {LVL_W{1'b0}});
        wr_ptr_d  = push_ok_s ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d  = pop_ok_s ? rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/sound_cmd_port.sv
// Round-robin command intake, FIFO buffering and timed replay onto the
// sound board's active-low pb/hand lines (one CB1 edge per command).
module sound_cmd_port
    import snd_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CMD_W    = 6,
    parameter int DEPTH    = 4,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 8
) (
    input  logic                       clk_cpu,
    input  logic                       reset,
    input  logic [NCH-1:0]             req_valid,
    input  logic [NCH*CMD_W-1:0]       req_cmd,
    output logic [NCH-1:0]             req_ready,
    output logic [CMD_W-1:0]           pb,
    output logic                       hand,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int RR_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = cnt_width(HOLD_CYC, GAP_CYC);

    localparam logic [CMD_W-1:0] PB_IDLE   = CMD_W'(pb_idle(CMD_W));
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : {CNT_W{1'b0}};

    logic [CMD_W-1:0] cmd_arr_s [NCH];
    logic [RR_W-1:0]  rr_q, rr_d;
    logic [RR_W-1:0]  gnt_idx_s;
    logic [RR_W:0]    arb_sum_s;
    logic [RR_W:0]    rr_nxt_s;
    logic             found_s;
    logic             can_accept_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic [CMD_W-1:0] head_s;
    logic [LVL_W-1:0] level_s;

    snd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CMD_W-1:0] pb_q, pb_d;
    logic             hand_q, hand_d;

    for (genvar g = 0; g < NCH; g++) begin : g_cmd
        assign cmd_arr_s[g] = req_cmd[g*CMD_W +: CMD_W];
    end

    // Round-robin search from rr; grant is suppressed while full or in reset.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = rr_q;
        arb_sum_s = {(RR_W+1){1'b0}};
        for (int off = 0; off < NCH; off++) begin
            arb_sum_s = {1'b0, rr_q} + (RR_W+1)'(off);
            arb_sum_s = (arb_sum_s >= (RR_W+1)'(NCH)) ? arb_sum_s - (RR_W+1)'(NCH) : arb_sum_s;
            gnt_idx_s = (!found_s && req_valid[arb_sum_s[RR_W-1:0]]) ? arb_sum_s[RR_W-1:0] : gnt_idx_s;
            found_s   = found_s | req_valid[arb_sum_s[RR_W-1:0]];
        end
        can_accept_s = !reset && (level_s < LVL_W'(DEPTH));
        for (int i = 0; i < NCH; i++) begin
            req_ready[i] = found_s && can_accept_s && (gnt_idx_s == RR_W'(i));
        end
        accept_s = found_s && can_accept_s;
        push_s   = accept_s && (cmd_arr_s[gnt_idx_s] != {CMD_W{1'b0}});
        rr_nxt_s = {1'b0, gnt_idx_s} + {{RR_W{1'b0}}, 1'b1};
        if (accept_s) begin
            rr_d = (rr_nxt_s >= (RR_W+1)'(NCH)) ? {RR_W{1'b0}} : rr_nxt_s[RR_W-1:0];
        end else begin
            rr_d = rr_q;
        end
    end

    // Replay sequencer: IDLE pops, DRIVE holds the strobe, GAP enforces recovery.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pb_d    = pb_q;
        hand_d  = hand_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_s != {LVL_W{1'b0}}) begin
                    pop_s   = 1'b1;
                    pb_d    = ~head_s;
                    hand_d  = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_DRIVE;
                end else begin
                    pb_d    = PB_IDLE;
                    hand_d  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    pb_d    = PB_IDLE;
                    hand_d  = 1'b1;
                    cnt_d   = GAP_LOAD;
                    state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP: begin
                pb_d   = PB_IDLE;
                hand_d = 1'b1;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                pb_d    = PB_IDLE;
                hand_d  = 1'b1;
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer, arbiter pointer and board-facing output registers.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            pb_q    <= PB_IDLE;
            hand_q  <= 1'b1;
            rr_q    <= {RR_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pb_q    <= pb_d;
            hand_q  <= hand_d;
            rr_q    <= rr_d;
        end
    end

    snd_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk_i   (clk_cpu),
        .reset_i (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (cmd_arr_s[gnt_idx_s]),
        .rdata_o (head_s),
        .level_o (level_s)
    );

    assign pb    = pb_q;
    assign hand  = hand_q;
    assign level = level_s;
    assign busy  = (level_s != {LVL_W{1'b0}}) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_cmd_port.sv
// Directed plus randomized bench for sound_cmd_port; expected behaviour comes
// from a timeline model (accept edge -> pop edge -> hold/gap windows).
module tb_sound_cmd_port;

    localparam int NCH      = 2;
    localparam int CMD_W    = 6;
    localparam int DEPTH    = 4;
    localparam int HOLD_CYC = 16;
    localparam int GAP_CYC  = 8;
    localparam int LVL_W    = $clog2(DEPTH + 1);

    logic                   clk_cpu = 1'b0;
    logic                   reset;
    logic [NCH-1:0]         req_valid;
    logic [NCH*CMD_W-1:0]   req_cmd;
    logic [NCH-1:0]         req_ready;
    logic [CMD_W-1:0]       pb;
    logic                   hand;
    logic                   busy;
    logic [LVL_W-1:0]       level;

    always #5 clk_cpu = ~clk_cpu;

    sound_cmd_port #(
        .NCH(NCH), .CMD_W(CMD_W), .DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_ready (req_ready),
        .pb        (pb),
        .hand      (hand),
        .busy      (busy),
        .level     (level)
    );

    // One accepted non-zero command: when it entered and when it was popped.
    typedef struct {
        logic [CMD_W-1:0] cmd;
        int               push_e;
        int               pop_e;
    } item_t;

    item_t q[$];
    int    edge_n     = 0;
    int    rr_m       = 0;
    int    last_pop   = -1000;
    int    vectors    = 0;
    int    miscompares = 0;

    function automatic int occupancy_after(int n);
        int c = 0;
        foreach (q[i]) if (q[i].push_e <= n && q[i].pop_e > n) c++;
        return c;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic cycle();
        int               gidx;
        logic [NCH-1:0]   exp_rdy;
        logic [CMD_W-1:0] c;
        logic [CMD_W-1:0] exp_pb;
        logic             exp_hand;
        logic             exp_busy;
        int               p;
        #2;
        gidx    = -1;
        exp_rdy = '0;
        if (!reset && occupancy_after(edge_n) < DEPTH) begin
            for (int off = 0; off < NCH; off++) begin
                if (gidx < 0 && req_valid[(rr_m + off) % NCH]) gidx = (rr_m + off) % NCH;
            end
        end
        if (gidx >= 0) exp_rdy[gidx] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk_cpu);
        edge_n++;
        if (reset) begin
            q.delete();
            rr_m     = 0;
            last_pop = -1000;
        end else if (gidx >= 0) begin
            c    = req_cmd[gidx*CMD_W +: CMD_W];
            rr_m = (gidx + 1) % NCH;
            if (c != '0) begin
                p = edge_n + 1;
                if (last_pop + 1 + HOLD_CYC + GAP_CYC > p) p = last_pop + 1 + HOLD_CYC + GAP_CYC;
                q.push_back('{c, edge_n, p});
                last_pop = p;
            end
        end
        #1;
        exp_pb   = '1;
        exp_hand = 1'b1;
        exp_busy = 1'b0;
        foreach (q[i]) begin
            if (q[i].pop_e <= edge_n && edge_n < q[i].pop_e + HOLD_CYC) begin
                exp_pb   = ~q[i].cmd;
                exp_hand = 1'b0;
            end
            if (q[i].push_e <= edge_n && edge_n < q[i].pop_e + HOLD_CYC + GAP_CYC) exp_busy = 1'b1;
        end
        check("pb",    32'(pb),    32'(exp_pb));
        check("hand",  32'(hand),  32'(exp_hand));
        check("busy",  32'(busy),  32'(exp_busy));
        check("level", 32'(level), 32'(occupancy_after(edge_n)));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drive(logic v0, logic [CMD_W-1:0] c0, logic v1, logic [CMD_W-1:0] c1);
        req_valid = {v1, v0};
        req_cmd   = {c1, c0};
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 6'h00, 1'b0, 6'h00);
        run(20);
        reset = 1'b0;
        run(3);

        // Single command from source 0.
        drive(1'b1, 6'h0A, 1'b0, 6'h00);
        cycle();
        drive(1'b0, 6'h00, 1'b0, 6'h00);
        run(30);

        // Both sources hammering; fills the FIFO and alternates grants.
        drive(1'b1, 6'h01, 1'b1, 6'h02);
        run(130);
        drive(1'b0, 6'h00, 1'b0, 6'h00);
        run(150);

        // No-op command from source 1.
        drive(1'b0, 6'h00, 1'b1, 6'h00);
        cycle();
        drive(1'b0, 6'h00, 1'b0, 6'h00);
        run(10);

        // Queue several commands, then reset mid-drive.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'(8'h11 + 8'(i) * 8'h05), 1'b0, 6'h00);
            cycle();
        end
        drive(1'b0, 6'h00, 1'b0, 6'h00);
        run(3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(40);

        // Randomized traffic with occasional zero commands and resets.
        for (int i = 0; i < 1500; i++) begin
            req_valid = NCH'($urandom_range(0, 3));
            for (int s = 0; s < NCH; s++) begin
                req_cmd[s*CMD_W +: CMD_W] = ($urandom_range(0, 3) == 0) ? '0 : CMD_W'($urandom);
            end
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        drive(1'b0, 6'h00, 1'b0, 6'h00);
        run(150);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
